alu_issue_queue: RTL and testbench

Operation buffer and result register for the 5-bit shift+ALU datapath. Upstream logic pushes complete ALU operations (operands, ALU control, shift amount, shift direction) through a valid/ready handshake into a small FIFO. The block presents the head entry to the combinational shift+ALU stage, captures the returned Result/ALUFlags in an output register, and hands them downstream with a second valid/ready handshake. It decouples the combinational ALU from its producer and its consumer and supports one operation per cycle.

---
 rtl/alu_issue_queue.sv | 138 +++++++++++++
 tb/tb_alu_issue_queue.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Operation FIFO and result register in front of the 5-bit shift+ALU stage.
// The head entry drives the ALU; its result is captured on issue and held for the consumer.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_a,
    input  logic [4:0]               in_b,
    input  logic [2:0]               in_ctrl,
    input  logic [1:0]               in_shift,
    input  logic                     in_dir,
    output logic [4:0]               alu_a,
    output logic [4:0]               alu_b,
    output logic [2:0]               alu_ctrl,
    output logic [1:0]               alu_shift,
    output logic                     alu_dir,
    input  logic [4:0]               alu_result,
    input  logic [3:0]               alu_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_result,
    output logic [3:0]               out_flags,
    output logic [TAGW-1:0]          out_tag,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 16 + TAGW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            out_valid_q, out_valid_d;
    logic [4:0]      out_result_q, out_result_d;
    logic [3:0]      out_flags_q, out_flags_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic            out_illegal_q, out_illegal_d;

    logic [EW-1:0]   head;
    logic            empty;
    logic            push;
    logic            issue;
    logic            head_illegal;

    assign head         = mem_q[rd_ptr_q];
    assign empty        = (count_q == '0);
    assign in_ready     = (count_q != FULL);
    assign push         = in_valid & in_ready;
    assign issue        = ~empty & (~out_valid_q | out_ready);
    assign head_illegal = (head[12:11] == 2'b11);

    assign alu_a     = empty ? 5'd0 : head[4:0];
    assign alu_b     = empty ? 5'd0 : head[9:5];
    assign alu_ctrl  = empty ? 3'd0 : head[12:10];
    assign alu_shift = empty ? 2'd0 : head[14:13];
    assign alu_dir   = empty ? 1'b0 : head[15];

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_flags   = out_flags_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;
    assign count       = count_q;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_flags_d   = out_flags_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;

        if (push) begin
            mem_d[wr_ptr_q] = {tag_q, in_dir, in_shift, in_ctrl, in_b, in_a};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            tag_d           = tag_q + TAGW'(1);
        end

        if (issue) begin
            rd_ptr_d      = rd_ptr_q + PW'(1);
            out_valid_d   = 1'b1;
            out_tag_d     = head[16 +: TAGW];
            out_illegal_d = head_illegal;
            // Illegal codes report a fixed zero result instead of the ALU output
            out_result_d  = head_illegal ? 5'd0 : alu_result;
            out_flags_d   = head_illegal ? 4'b0100 : alu_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_flags_q   <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_flags_q   <= out_flags_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural shift+ALU stage.
module tb_alu_issue_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_a = '0, in_b = '0;
    logic [2:0] in_ctrl = '0;
    logic [1:0] in_shift = '0;
    logic       in_dir = 1'b0;
    logic [4:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [1:0] alu_shift;
    logic       alu_dir;
    logic [4:0] alu_result;
    logic [3:0] alu_flags;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_tag;
    logic       out_illegal;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;
    logic [12:0] sb[$];
    logic [2:0]  exp_tag = '0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4), .TAGW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .in_shift(in_shift), .in_dir(in_dir),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_shift(alu_shift), .alu_dir(alu_dir),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .out_tag(out_tag), .out_illegal(out_illegal),
        .count(count)
    );

    // Returns {result, neg, zero, carry, overflow}; illegal codes return garbage
    function automatic logic [8:0] alu_f(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] c, input logic [1:0] sh,
                                         input logic d);
        logic [4:0] bs, r;
        logic [5:0] s;
        logic cy, ov;
        bs = d ? (b >> sh) : (b << sh);
        cy = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (c)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, bs};
                r  = s[4:0];
                cy = s[5];
                ov = (a[4] == bs[4]) && (r[4] != a[4]);
            end
            3'd1: begin
                s  = {1'b0, a} + {1'b0, ~bs} + 6'd1;
                r  = s[4:0];
                cy = s[5];
                ov = (a[4] != bs[4]) && (r[4] != a[4]);
            end
            3'd2: r = a & bs;
            3'd3: r = a | bs;
            3'd4: r = a ^ bs;
            3'd5: r = ($signed(a) < $signed(bs)) ? 5'd1 : 5'd0;
            default: return {5'h15, 4'hf};
        endcase
        return {r, r[4], r == 5'd0, cy, ov};
    endfunction

    assign {alu_result, alu_flags} = alu_f(alu_a, alu_b, alu_ctrl, alu_shift, alu_dir);

    function automatic logic [12:0] exp_of(input logic [2:0] tag);
        logic [8:0] f;
        if (in_ctrl[2:1] == 2'b11) return {1'b1, tag, 4'b0100, 5'd0};
        f = alu_f(in_a, in_b, in_ctrl, in_shift, in_dir);
        return {1'b0, tag, f[3:0], f[8:4]};
    endfunction

    // Record this cycle's handshakes, then advance to the next falling edge
    task automatic tick();
        logic [12:0] got, e;
        #1;
        if (!reset && in_valid && in_ready) begin
            sb.push_back(exp_of(exp_tag));
            exp_tag = exp_tag + 3'd1;
        end
        if (!reset && out_valid && out_ready) begin
            got = {out_illegal, out_tag, out_flags, out_result};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h required=none", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_result got=%h required=%h", got, e);
                end
            end
        end
        if (reset) begin
            sb.delete();
            exp_tag = '0;
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [4:0] a, input logic [4:0] b, input logic [2:0] c,
                          input logic [1:0] sh, input logic d);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ctrl  = c;
        in_shift = sh;
        in_dir   = d;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) tick();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d required=0", count); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
        checks++;
        if ({out_result, out_flags, out_tag, out_illegal} !== 13'd0) begin
            failures++;
            $display("FAIL rst_out_data got=%h required=0", {out_result, out_flags, out_tag, out_illegal});
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl, alu_shift, alu_dir} !== 16'd0) begin
            failures++;
            $display("FAIL rst_alu_empty got=%h required=0", {alu_a, alu_b, alu_ctrl, alu_shift, alu_dir});
        end
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        set_op(5'd3, 5'd1, 3'b000, 2'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            failures++;
            $display("FAIL single_n1 got=%b/%0d required=0/1", out_valid, count);
        end
        checks++;
        if (alu_a !== 5'd3 || alu_b !== 5'd1 || alu_shift !== 2'd2) begin
            failures++;
            $display("FAIL single_head got=%0d/%0d/%0d required=3/1/2", alu_a, alu_b, alu_shift);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b required=1", out_valid); end
        checks++;
        if (out_result !== 5'd7 || out_flags !== 4'b0000 || out_tag !== 3'd0) begin
            failures++;
            $display("FAIL single_data got=%0d/%b/%0d required=7/0000/0", out_result, out_flags, out_tag);
        end
        drain();
    endtask

    task automatic test_sub();
        out_ready = 1'b0;
        set_op(5'd2, 5'd3, 3'b001, 2'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_result !== 5'b11111 || out_flags[3] !== 1'b1 || out_flags[1] !== 1'b0) begin
            failures++;
            $display("FAIL sub_underflow got=%b/%b required=11111/1x0x", out_result, out_flags);
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(5'(i), 5'(i + 1), 3'b000, 2'd0, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept%0d got=0 required=1", i); end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL bp_full got=%b/%0d required=0/4", in_ready, count);
        end
        set_op(5'd9, 5'd9, 3'b000, 2'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || out_valid !== 1'b1 || out_tag !== 3'd0 || out_result !== 5'd1) begin
            failures++;
            $display("FAIL bp_hold got=%0d/%b/%0d/%0d required=4/1/0/1", count, out_valid, out_tag, out_result);
        end
        drain();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_op(5'd1, 5'd2, 3'b000, 2'd0, 1'b0);
        tick();
        set_op(5'd7, 5'd7, 3'b111, 2'd1, 1'b1);
        tick();
        set_op(5'd4, 5'd4, 3'b000, 2'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_illegal !== 1'b1 || out_result !== 5'd0 || out_flags !== 4'b0100) begin
            failures++;
            $display("FAIL illegal_mid got=%b/%0d/%b required=1/0/0100", out_illegal, out_result, out_flags);
        end
        drain();
    endtask

    task automatic test_stream();
        int nv, first, last;
        do_reset();
        out_ready = 1'b1;
        nv = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 10) set_op(5'($urandom), 5'($urandom), 3'($urandom_range(0, 5)),
                               2'($urandom), 1'($urandom));
            else in_valid = 1'b0;
            tick();
            if (out_valid) begin
                nv++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (nv !== 10 || (last - first + 1) !== 10) begin
            failures++;
            $display("FAIL stream_rate got=%0d/%0d required=10/10", nv, last - first + 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(5'(i + 3), 5'd1, 3'b010, 2'd0, 1'b0);
            tick();
        end
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre got=%0d/%b required=3/1", count, out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_post got=%0d/%b/%b required=0/0/1", count, out_valid, in_ready);
        end
        out_ready = 1'b0;
        set_op(5'd5, 5'd6, 3'b100, 2'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 3'd0) begin
            failures++;
            $display("FAIL rmid_tag got=%b/%0d required=1/0", out_valid, out_tag);
        end
        drain();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_sub();
        test_backpressure();
        test_illegal();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
